regbank_wr_arb: RTL

//   Write arbiter for the 1553B register bank. Shares NREG enable-registers between the APB host
//   and the 1553B protocol core. Selects one writer per transaction, drives a one-hot write-enable

---
 rtl/regbank_wr_arb_pkg.sv | 19 +
 rtl/arb_starve_cnt.sv | 35 +++
 rtl/regbank_wr_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/regbank_wr_arb_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state and grant-source encodings
// plus default bank geometry.
package regbank_defs;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef enum logic {
        GNT_CORE = 1'b0,
        GNT_APB  = 1'b1
    } gnt_t;

    localparam int DEF_DW   = 16;
    localparam int DEF_NREG = 8;
    localparam int DEF_AW   = 3;

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive core grants taken while APB was waiting; raises force_apb once the
// count reaches MAX_WAIT so the next IDLE decision goes to APB.
module arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic upd,
    input  logic apb_req,
    input  logic apb_gnt,
    input  logic core_gnt,
    output logic force_apb
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_reg;

    // Only IDLE cycles carry an arbitration decision, so the count moves only then.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (upd) begin
            if (!apb_req || apb_gnt) begin
                cnt_reg <= '0;
            end else if (core_gnt && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign force_apb = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/regbank_wr_arb.sv
// Write arbiter sharing NREG bank registers between the APB host and the 1553B core.
// Define REG_ARB_XCHECK_EN to add a simulation-only X/one-hot/ack checker.
module regbank_wr_arb
    import regbank_defs::*;
#(
    parameter int DW       = DEF_DW,
    parameter int NREG     = DEF_NREG,
    parameter int AW       = DEF_AW,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            apb_req,
    input  logic [AW-1:0]   apb_addr,
    input  logic [DW-1:0]   apb_wdata,
    output logic            apb_ack,
    input  logic            core_req,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_ack,
    output logic            addr_err,
    output logic [NREG-1:0] reg_en,
    output logic [DW-1:0]   reg_wdata
);

    state_t          state_reg;
    logic            force_apb;
    logic            is_idle;
    logic            any_req;
    logic            apb_win;
    gnt_t            gnt_src;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            addr_ok;
    logic [NREG-1:0] dec;

    assign is_idle   = (state_reg == IDLE);
    assign any_req   = apb_req | core_req;
    // Core has priority unless APB has been passed over MAX_WAIT times in a row.
    assign apb_win   = apb_req && (!core_req || force_apb);
    assign gnt_src   = apb_win ? GNT_APB : GNT_CORE;
    assign sel_addr  = (gnt_src == GNT_APB) ? apb_addr  : core_addr;
    assign sel_wdata = (gnt_src == GNT_APB) ? apb_wdata : core_wdata;
    assign addr_ok   = (int'(sel_addr) < NREG);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            assign dec[gi] = addr_ok && (sel_addr == AW'(gi));
        end
    endgenerate

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .upd       (is_idle),
        .apb_req   (apb_req),
        .apb_gnt   (apb_win),
        .core_gnt  (core_req && !apb_win),
        .force_apb (force_apb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            reg_en    <= '0;
            reg_wdata <= '0;
            apb_ack   <= 1'b0;
            core_ack  <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            reg_en   <= '0;
            apb_ack  <= 1'b0;
            core_ack <= 1'b0;
            addr_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg <= WRITE;
                        reg_en    <= dec;
                        apb_ack   <= (gnt_src == GNT_APB);
                        core_ack  <= (gnt_src == GNT_CORE);
                        addr_err  <= !addr_ok;
                        // A rejected write leaves the data bus untouched.
                        if (addr_ok) begin
                            reg_wdata <= sel_wdata;
                        end
                    end
                end
                WRITE:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef REG_ARB_XCHECK_EN
    always @(posedge clk) begin
        if (!rst && ($isunknown(apb_req) || $isunknown(core_req))) begin
            $error("regbank_wr_arb: X on request input");
        end
        if (!$onehot0(reg_en)) begin
            $error("regbank_wr_arb: reg_en not zero/one-hot: %b", reg_en);
        end
        if (apb_ack && core_ack) begin
            $error("regbank_wr_arb: both acks high");
        end
    end
`else
    // Checker not built; logic above is identical either way.
`endif

endmodule
